gpio_in_cond: RTL and testbench



---
 rtl/gpio_in_cond_pkg.sv | 18 +
 rtl/gpio_in_cond_if.sv | 42 ++++
 rtl/gpio_in_cond_bit.sv | 97 +++++++++
 rtl/gpio_in_cond.sv | 53 +++++
 tb/tb_gpio_in_cond.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/gpio_in_cond_pkg.sv
// gpio_cond_pkg: constants and types shared by the GPIO input-conditioning slice.
//   GPIO_WIDTH  - default number of conditioned pad bits
//   DEB_W       - default width of the per-bit debounce counter and deb_limit
//   irq_mode_e  - per-bit interrupt mode (EDGE or LEVEL)
//   STABLE_RST  - reset value of the debounced level
package gpio_cond_pkg;

  localparam int unsigned GPIO_WIDTH = 16;
  localparam int unsigned DEB_W      = 8;

  typedef enum logic {
    EDGE  = 1'b0,
    LEVEL = 1'b1
  } irq_mode_e;

  localparam logic STABLE_RST = 1'b0;

endpackage

// File: rtl/gpio_in_cond_if.sv
// gpio_in_cond_if: groups the gpio_in_cond bus signals.
//   master modport - SoC side: drives pad inputs and controls, reads results
//   slave modport  - conditioner side
//   Signals: pad_di, deb_limit, irq_rise_en, irq_fall_en, irq_clr (to slave);
//            gpio_in, irq_pending, irq_gpio (from slave);
//            irq_level (to slave) only when GPIO_COND_LEVEL_IRQ_EN is defined.
interface gpio_in_cond_if
  import gpio_cond_pkg::*;
#(
  parameter int unsigned WIDTH = gpio_cond_pkg::GPIO_WIDTH,
  parameter int unsigned DEB_W = gpio_cond_pkg::DEB_W
);

  logic [WIDTH-1:0] pad_di;
  logic [DEB_W-1:0] deb_limit;
  logic [WIDTH-1:0] irq_rise_en;
  logic [WIDTH-1:0] irq_fall_en;
  logic [WIDTH-1:0] irq_clr;
`ifdef GPIO_COND_LEVEL_IRQ_EN
  logic [WIDTH-1:0] irq_level;
`endif
  logic [WIDTH-1:0] gpio_in;
  logic [WIDTH-1:0] irq_pending;
  logic             irq_gpio;

  modport master (
    output pad_di, deb_limit, irq_rise_en, irq_fall_en, irq_clr,
`ifdef GPIO_COND_LEVEL_IRQ_EN
    output irq_level,
`endif
    input  gpio_in, irq_pending, irq_gpio
  );

  modport slave (
    input  pad_di, deb_limit, irq_rise_en, irq_fall_en, irq_clr,
`ifdef GPIO_COND_LEVEL_IRQ_EN
    input  irq_level,
`endif
    output gpio_in, irq_pending, irq_gpio
  );

endinterface

// File: rtl/gpio_in_cond_bit.sv
// gpio_cond_bit: conditioning for one GPIO bit.
//   Two-flop synchronizer, debounce counter, stable level flop and sticky
//   interrupt-pending flag (edge or level mode).
//   Ports:
//     clk, resetn    - core clock, synchronous active-low reset
//     i_pad          - raw asynchronous pad input
//     i_deb_limit    - debounce length in cycles, 0 = bypass
//     i_rise_en      - rising-edge (level mode: high-level) interrupt enable
//     i_fall_en      - falling-edge (level mode: low-level) interrupt enable
//     i_clr          - single-cycle clear of pending
//     i_level        - 1 selects level mode
//     o_level        - debounced, synchronized level
//     o_pending      - sticky pending flag
module gpio_cond_bit
  import gpio_cond_pkg::*;
#(
  parameter int unsigned DEB_W = gpio_cond_pkg::DEB_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_pad,
  input  logic [DEB_W-1:0] i_deb_limit,
  input  logic             i_rise_en,
  input  logic             i_fall_en,
  input  logic             i_clr,
  input  logic             i_level,
  output logic             o_level,
  output logic             o_pending
);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [DEB_W-1:0] r_cnt;
  logic             r_pending;

  logic             w_stable_nxt;
  logic [DEB_W-1:0] w_cnt_nxt;
  logic [DEB_W:0]   w_cnt_inc;
  logic             w_rise;
  logic             w_fall;
  logic             w_edge_set;
  logic             w_lvl_set;
  logic             w_set;
  logic             w_pending_nxt;
  irq_mode_e        w_mode;

  // Increment is one bit wider so the compare never sees a wrapped count.
  assign w_cnt_inc = {1'b0, r_cnt} + {{DEB_W{1'b0}}, 1'b1};

  always_comb begin
    w_stable_nxt = r_stable;
    w_cnt_nxt    = '0;
    if (i_deb_limit == '0) begin
      w_stable_nxt = r_s2;
    end else if (r_s2 == r_stable) begin
      w_cnt_nxt = '0;
    end else if (w_cnt_inc >= {1'b0, i_deb_limit}) begin
      w_stable_nxt = r_s2;
      w_cnt_nxt    = '0;
    end else begin
      w_cnt_nxt = w_cnt_inc[DEB_W-1:0];
    end
  end

  // Edges come from the next stable value so pending sets on the same edge
  // that the debounced level changes.
  assign w_rise     = ~r_stable &  w_stable_nxt;
  assign w_fall     =  r_stable & ~w_stable_nxt;
  assign w_edge_set = (w_rise & i_rise_en) | (w_fall & i_fall_en);
  assign w_lvl_set  = (r_stable & i_rise_en) | (~r_stable & i_fall_en);

  assign w_mode        = i_level ? LEVEL : EDGE;
  assign w_set         = (w_mode == LEVEL) ? w_lvl_set : w_edge_set;
  // Set is OR-ed after the clear, so a simultaneous set wins.
  assign w_pending_nxt = (r_pending & ~i_clr) | w_set;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_stable  <= STABLE_RST;
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_s1      <= i_pad;
      r_s2      <= r_s1;
      r_stable  <= w_stable_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  assign o_level   = r_stable;
  assign o_pending = r_pending;

endmodule

// File: rtl/gpio_in_cond.sv
// gpio_in_cond: input-conditioning stage between the pad DI outputs and the
// core gpio_in bus. Instantiates one gpio_cond_bit per bit and ORs the
// pending flags into a single interrupt line.
//   Ports:
//     clk    - core clock
//     resetn - synchronous active-low reset
//     bus    - gpio_in_cond_if.slave: pad_di, deb_limit, irq_rise_en,
//              irq_fall_en, irq_clr in; gpio_in, irq_pending, irq_gpio out
//   Build option: GPIO_COND_LEVEL_IRQ_EN adds bus.irq_level (per-bit level
//   interrupt mode); when undefined all bits run in edge mode.
module gpio_in_cond
  import gpio_cond_pkg::*;
#(
  parameter int unsigned WIDTH = gpio_cond_pkg::GPIO_WIDTH,
  parameter int unsigned DEB_W = gpio_cond_pkg::DEB_W
) (
  input  logic           clk,
  input  logic           resetn,
  gpio_in_cond_if.slave  bus
);

  logic [WIDTH-1:0] w_level_mode;
  logic [WIDTH-1:0] w_gpio;
  logic [WIDTH-1:0] w_pending;

`ifdef GPIO_COND_LEVEL_IRQ_EN
  assign w_level_mode = bus.irq_level;
`else
  assign w_level_mode = '0;
`endif

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    gpio_cond_bit #(
      .DEB_W (DEB_W)
    ) u_bit (
      .clk         (clk),
      .resetn      (resetn),
      .i_pad       (bus.pad_di[g]),
      .i_deb_limit (bus.deb_limit),
      .i_rise_en   (bus.irq_rise_en[g]),
      .i_fall_en   (bus.irq_fall_en[g]),
      .i_clr       (bus.irq_clr[g]),
      .i_level     (w_level_mode[g]),
      .o_level     (w_gpio[g]),
      .o_pending   (w_pending[g])
    );
  end

  assign bus.gpio_in     = w_gpio;
  assign bus.irq_pending = w_pending;
  assign bus.irq_gpio    = |w_pending;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Testbench for gpio_in_cond: directed table vectors in bypass mode plus
// hand-written multi-cycle sequences for debounce, clear/set and limit change.
module tb_gpio_in_cond;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;

  gpio_in_cond_if #(.WIDTH(16), .DEB_W(8)) bus ();

  gpio_in_cond #(.WIDTH(16), .DEB_W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pad;
    logic [15:0] ren;
    logic [15:0] fen;
    logic [15:0] clr;
    logic [15:0] exp_gpio;
    logic [15:0] exp_pend;
    logic [15:0] exp_pend_clr;
  } vec_t;

  vec_t vecs [6];

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    bus.pad_di      = 16'hFFFF;
    bus.deb_limit   = 8'd0;
    bus.irq_rise_en = 16'h0000;
    bus.irq_fall_en = 16'h0000;
    bus.irq_clr     = 16'h0000;
`ifdef GPIO_COND_LEVEL_IRQ_EN
    bus.irq_level   = 16'h0000;
`endif

    vecs[0] = '{16'h00FF, 16'h000F, 16'h0000, 16'h0000, 16'h00FF, 16'h000F, 16'h000F};
    vecs[1] = '{16'h0F0F, 16'hFFFF, 16'h00F0, 16'h0FF0, 16'h0F0F, 16'h0FFF, 16'h000F};
    vecs[2] = '{16'hF000, 16'h0000, 16'h0003, 16'hFFFF, 16'hF000, 16'h000F, 16'h0000};
    vecs[3] = '{16'hF000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hF000, 16'h0000, 16'h0000};
    vecs[4] = '{16'h8001, 16'h0001, 16'h1000, 16'h0001, 16'h8001, 16'h1001, 16'h1000};
    vecs[5] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'h1000};

    // Reset with pads high.
    step(4);
    chk("rst_gpio", 32'(bus.gpio_in), 32'h0);
    chk("rst_pend", 32'(bus.irq_pending), 32'h0);
    chk("rst_irq", 32'(bus.irq_gpio), 32'h0);
    resetn = 1'b1;
    step(2);
    chk("rel_gpio_2cyc", 32'(bus.gpio_in), 32'h0);
    step(1);
    chk("rel_gpio_3cyc", 32'(bus.gpio_in), 32'hFFFF);
    bus.pad_di = 16'h0000;
    step(4);
    chk("rel_gpio_low", 32'(bus.gpio_in), 32'h0);
    chk("rel_pend", 32'(bus.irq_pending), 32'h0);

    // Table vectors, bypass debounce.
    for (int v = 0; v < 6; v++) begin
      bus.pad_di      = vecs[v].pad;
      bus.irq_rise_en = vecs[v].ren;
      bus.irq_fall_en = vecs[v].fen;
      step(4);
      chk($sformatf("v%0d_gpio", v), 32'(bus.gpio_in), 32'(vecs[v].exp_gpio));
      chk($sformatf("v%0d_pend", v), 32'(bus.irq_pending), 32'(vecs[v].exp_pend));
      chk($sformatf("v%0d_irq", v), 32'(bus.irq_gpio), 32'(vecs[v].exp_pend != 16'h0));
      bus.irq_clr = vecs[v].clr;
      step(1);
      bus.irq_clr = 16'h0000;
      chk($sformatf("v%0d_pend_clr", v), 32'(bus.irq_pending), 32'(vecs[v].exp_pend_clr));
    end
    bus.irq_clr = 16'hFFFF;
    step(1);
    bus.irq_clr = 16'h0000;
    chk("tbl_cleared", 32'(bus.irq_pending), 32'h0);

    // Edge irq on bit 0.
    bus.irq_rise_en = 16'h0001;
    bus.irq_fall_en = 16'h0000;
    bus.pad_di      = 16'h0001;
    step(2);
    chk("edge_pend_early", 32'(bus.irq_pending), 32'h0);
    step(1);
    chk("edge_gpio", 32'(bus.gpio_in), 32'h0001);
    chk("edge_pend", 32'(bus.irq_pending), 32'h0001);
    chk("edge_irq", 32'(bus.irq_gpio), 32'h1);
    bus.irq_clr = 16'h0001;
    step(1);
    bus.irq_clr = 16'h0000;
    chk("lone_clr_pend", 32'(bus.irq_pending), 32'h0);
    chk("lone_clr_irq", 32'(bus.irq_gpio), 32'h0);
    bus.pad_di = 16'h0000;
    step(4);
    chk("fall_noen_gpio", 32'(bus.gpio_in), 32'h0);
    chk("fall_noen_pend", 32'(bus.irq_pending), 32'h0);

    // Clear coinciding with a new rise: set wins.
    bus.pad_di = 16'h0001;
    step(2);
    bus.irq_clr = 16'h0001;
    step(1);
    bus.irq_clr = 16'h0000;
    chk("clr_vs_set", 32'(bus.irq_pending), 32'h0001);
    bus.irq_clr = 16'h0001;
    step(1);
    bus.irq_clr = 16'h0000;
    chk("clr_after", 32'(bus.irq_pending), 32'h0);
    bus.irq_rise_en = 16'h0000;
    bus.pad_di = 16'h0000;
    step(4);

    // Debounce: a 4-cycle glitch is filtered with deb_limit=5.
    bus.deb_limit = 8'd5;
    bus.pad_di = 16'h0008;
    step(4);
    bus.pad_di = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk($sformatf("glitch_c%0d", i), 32'(bus.gpio_in[3]), 32'h0);
    end
    // Held high: rises 2+5 cycles after the pad edge.
    bus.pad_di = 16'h0008;
    step(6);
    chk("deb_6cyc", 32'(bus.gpio_in[3]), 32'h0);
    step(1);
    chk("deb_7cyc", 32'(bus.gpio_in[3]), 32'h1);
    bus.pad_di = 16'h0000;
    step(10);
    chk("deb_fall", 32'(bus.gpio_in), 32'h0);

    // Lowering the limit below a running count flips on the next edge.
    bus.deb_limit = 8'd200;
    bus.pad_di = 16'h0080;
    step(50);
    chk("lim_before", 32'(bus.gpio_in[7]), 32'h0);
    bus.deb_limit = 8'd10;
    step(1);
    chk("lim_after", 32'(bus.gpio_in[7]), 32'h1);
    bus.pad_di = 16'h0000;
    step(12);
    chk("lim_fall", 32'(bus.gpio_in), 32'h0);

    // Reset in the middle of a debounce discards the count.
    bus.deb_limit = 8'd5;
    bus.pad_di = 16'h0010;
    step(5);
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    step(6);
    chk("rst_mid_6cyc", 32'(bus.gpio_in[4]), 32'h0);
    step(1);
    chk("rst_mid_7cyc", 32'(bus.gpio_in[4]), 32'h1);
    bus.pad_di = 16'h0000;
    bus.deb_limit = 8'd0;
    step(4);

`ifdef GPIO_COND_LEVEL_IRQ_EN
    // Level mode: clear has no effect while the level persists.
    bus.irq_level   = 16'h0004;
    bus.irq_rise_en = 16'h0004;
    bus.irq_fall_en = 16'h0000;
    bus.pad_di      = 16'h0004;
    step(4);
    chk("lvl_pend", 32'(bus.irq_pending), 32'h0004);
    bus.irq_clr = 16'h0004;
    step(1);
    bus.irq_clr = 16'h0000;
    chk("lvl_clr_held", 32'(bus.irq_pending), 32'h0004);
    bus.pad_di = 16'h0000;
    step(5);
    chk("lvl_low_sticky", 32'(bus.irq_pending), 32'h0004);
    bus.irq_clr = 16'h0004;
    step(1);
    bus.irq_clr = 16'h0000;
    chk("lvl_clr_done", 32'(bus.irq_pending), 32'h0);
    chk("lvl_irq_done", 32'(bus.irq_gpio), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
